// File: rtl/hazard_pkg.sv
// hazard_pkg: forwarding encodings, multi-cycle FSM states and a saturating-increment helper.
package hazard_pkg;
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic {IDLE, BUSY} md_state_e;

   function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
      logic [63:0] max;
      max = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      return (v == max) ? v : v + 64'd1;
   endfunction
endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: per-operand E-stage forwarding select, M stage has priority over W.
module hazard_fwd_sel
   import hazard_pkg::*;
#(
   parameter int AW = 5
) (
   input  logic [AW-1:0] rs_e,
   input  logic [AW-1:0] rd_m,
   input  logic [AW-1:0] rd_w,
   input  logic          reg_write_m,
   input  logic          reg_write_w,
   output logic [1:0]    fwd
);
   always_comb
      fwd = (rs_e == '0)                   ? FWD_RF  :
            (reg_write_m && rs_e == rd_m)  ? FWD_MEM :
            (reg_write_w && rs_e == rd_w)  ? FWD_WB  : FWD_RF;
endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: forwarding, load-use stall, branch flush, multi-cycle E hold and
// saturating stall/flush performance counters for the 5-stage pipeline.
module hazard_unit_mc
   import hazard_pkg::*;
#(
   parameter int AW       = 5,
   parameter int MDIV_LAT = 8,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [AW-1:0]    Rs1D,
   input  logic [AW-1:0]    Rs2D,
   input  logic [AW-1:0]    Rs1E,
   input  logic [AW-1:0]    Rs2E,
   input  logic [AW-1:0]    RdE,
   input  logic [AW-1:0]    RdM,
   input  logic [AW-1:0]    RdW,
   input  logic             RegWriteE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             ResultSrcEb0,
   input  logic             MulDivE,
   input  logic             PCSrcE,
   input  logic             ClrCnt,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushM,
   output logic             MdBusy,
   output logic [CNT_W-1:0] StallCycles,
   output logic [CNT_W-1:0] FlushEvents
);
   localparam logic       MD_EN    = MDIV_LAT > 1;
   localparam logic [7:0] CNT_INIT = MD_EN ? 8'(MDIV_LAT - 2) : 8'd0;

   md_state_e        state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic             lw_stall, busy, md_start, md_stall;

   hazard_fwd_sel #(.AW(AW)) u_fwd_a (
      .rs_e(Rs1E), .rd_m(RdM), .rd_w(RdW),
      .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .fwd(ForwardAE)
   );
   hazard_fwd_sel #(.AW(AW)) u_fwd_b (
      .rs_e(Rs2E), .rd_m(RdM), .rd_w(RdW),
      .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .fwd(ForwardBE)
   );

   // A taken branch blocks the hold from starting; reset blocks it so stalls drop at once.
   always_comb begin
      lw_stall    = ResultSrcEb0 & RegWriteE & (RdE != '0) & ((Rs1D == RdE) | (Rs2D == RdE));
      busy        = state_q == BUSY;
      md_start    = ~busy & MulDivE & MD_EN & ~PCSrcE & ~reset;
      md_stall    = (busy & (cnt_q != 8'd0)) | md_start;
      MdBusy      = busy | (MulDivE & MD_EN & ~reset);
      StallF      = md_stall | lw_stall;
      StallD      = md_stall | lw_stall;
      StallE      = md_stall;
      FlushM      = md_stall;
      FlushD      = ~md_stall & ~busy & PCSrcE;
      FlushE      = ~md_stall & (lw_stall | (~busy & PCSrcE));
      state_d     = busy ? ((cnt_q != 8'd0) ? BUSY : IDLE) : (md_start ? BUSY : IDLE);
      cnt_d       = busy ? ((cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q) : (md_start ? CNT_INIT : cnt_q);
      stall_cnt_d = ClrCnt ? '0 : StallF ? CNT_W'(sat_inc(64'(stall_cnt_q), CNT_W)) : stall_cnt_q;
      flush_cnt_d = ClrCnt ? '0 : FlushD ? CNT_W'(sat_inc(64'(flush_cnt_q), CNT_W)) : flush_cnt_q;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end

   assign StallCycles = stall_cnt_q;
   assign FlushEvents = flush_cnt_q;
endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc: directed checks on four instances (MDIV_LAT 8/1/2, and 8 with a 4-bit counter).
module tb_hazard_unit_mc;
   logic       clk, reset;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic       RegWriteE, RegWriteM, RegWriteW, ResultSrcEb0, MulDivE, PCSrcE, ClrCnt;
   logic [1:0] fa [4];
   logic [1:0] fb [4];
   logic       sf [4];
   logic       sd [4];
   logic       se [4];
   logic       fd [4];
   logic       fe [4];
   logic       fm [4];
   logic       mb [4];
   logic [31:0] sc [3];
   logic [31:0] fc [3];
   logic [3:0]  sc4, fc4;
   int checks = 0, failures = 0;

   hazard_unit_mc #(.AW(5), .MDIV_LAT(8), .CNT_W(32)) u0 (
      .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .ResultSrcEb0(ResultSrcEb0), .MulDivE(MulDivE), .PCSrcE(PCSrcE),
      .ClrCnt(ClrCnt), .ForwardAE(fa[0]), .ForwardBE(fb[0]), .StallF(sf[0]), .StallD(sd[0]),
      .StallE(se[0]), .FlushD(fd[0]), .FlushE(fe[0]), .FlushM(fm[0]), .MdBusy(mb[0]),
      .StallCycles(sc[0]), .FlushEvents(fc[0]));
   hazard_unit_mc #(.AW(5), .MDIV_LAT(1), .CNT_W(32)) u1 (
      .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .ResultSrcEb0(ResultSrcEb0), .MulDivE(MulDivE), .PCSrcE(PCSrcE),
      .ClrCnt(ClrCnt), .ForwardAE(fa[1]), .ForwardBE(fb[1]), .StallF(sf[1]), .StallD(sd[1]),
      .StallE(se[1]), .FlushD(fd[1]), .FlushE(fe[1]), .FlushM(fm[1]), .MdBusy(mb[1]),
      .StallCycles(sc[1]), .FlushEvents(fc[1]));
   hazard_unit_mc #(.AW(5), .MDIV_LAT(2), .CNT_W(32)) u2 (
      .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .ResultSrcEb0(ResultSrcEb0), .MulDivE(MulDivE), .PCSrcE(PCSrcE),
      .ClrCnt(ClrCnt), .ForwardAE(fa[2]), .ForwardBE(fb[2]), .StallF(sf[2]), .StallD(sd[2]),
      .StallE(se[2]), .FlushD(fd[2]), .FlushE(fe[2]), .FlushM(fm[2]), .MdBusy(mb[2]),
      .StallCycles(sc[2]), .FlushEvents(fc[2]));
   hazard_unit_mc #(.AW(5), .MDIV_LAT(8), .CNT_W(4)) u3 (
      .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .ResultSrcEb0(ResultSrcEb0), .MulDivE(MulDivE), .PCSrcE(PCSrcE),
      .ClrCnt(ClrCnt), .ForwardAE(fa[3]), .ForwardBE(fb[3]), .StallF(sf[3]), .StallD(sd[3]),
      .StallE(se[3]), .FlushD(fd[3]), .FlushE(fe[3]), .FlushM(fm[3]), .MdBusy(mb[3]),
      .StallCycles(sc4), .FlushEvents(fc4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      #1;
   endtask

   initial begin
      {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
      {RegWriteE, RegWriteM, RegWriteW, ResultSrcEb0, MulDivE, PCSrcE, ClrCnt} = '0;
      reset = 1'b1;
      tick();
      chk("rst_stallf", 64'(sf[0]), 64'd0);
      chk("rst_mdbusy", 64'(mb[0]), 64'd0);
      chk("rst_stallcyc", 64'(sc[0]), 64'd0);
      chk("rst_flushev", 64'(fc[0]), 64'd0);
      reset = 1'b0;
      tick();

      Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs2E = 5'd3;
      #1;
      chk("fwdA_mem_prio", 64'(fa[0]), 64'd2);
      chk("fwdB_nomatch", 64'(fb[0]), 64'd0);
      RegWriteM = 1'b0;
      #1;
      chk("fwdA_wb", 64'(fa[0]), 64'd1);
      Rs1E = 5'd0;
      #1;
      chk("fwdA_x0", 64'(fa[0]), 64'd0);
      Rs2E = 5'd9; RdW = 5'd9; RdM = 5'd9;
      #1;
      chk("fwdB_wb", 64'(fb[0]), 64'd1);
      RegWriteM = 1'b1;
      #1;
      chk("fwdB_mem", 64'(fb[0]), 64'd2);
      {Rs1E, Rs2E, RdM, RdW, RegWriteM, RegWriteW} = '0;
      tick();

      pulse_reset();
      ResultSrcEb0 = 1'b1; RegWriteE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
      #1;
      chk("lw_stallf", 64'(sf[0]), 64'd1);
      chk("lw_stalld", 64'(sd[0]), 64'd1);
      chk("lw_flushe", 64'(fe[0]), 64'd1);
      chk("lw_stalle", 64'(se[0]), 64'd0);
      chk("lw_flushd", 64'(fd[0]), 64'd0);
      tick();
      ResultSrcEb0 = 1'b0; RegWriteE = 1'b0;
      #1;
      chk("lw_released", 64'(sf[0]), 64'd0);
      chk("lw_count", 64'(sc[0]), 64'd1);
      ResultSrcEb0 = 1'b1; RegWriteE = 1'b1; RdE = 5'd0; Rs2D = 5'd0;
      #1;
      chk("lw_rd0_stallf", 64'(sf[0]), 64'd0);
      chk("lw_rd0_flushe", 64'(fe[0]), 64'd0);
      {ResultSrcEb0, RegWriteE, RdE, Rs2D} = '0;
      tick();

      pulse_reset();
      MulDivE = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) PCSrcE = 1'b1;
         #1;
         if (i < 7) begin
            chk("md_stallf", 64'(sf[0]), 64'd1);
            chk("md_stalld", 64'(sd[0]), 64'd1);
            chk("md_stalle", 64'(se[0]), 64'd1);
            chk("md_flushm", 64'(fm[0]), 64'd1);
            chk("md_busy", 64'(mb[0]), 64'd1);
         end else begin
            chk("md_rel_stallf", 64'(sf[0]), 64'd0);
            chk("md_rel_stalle", 64'(se[0]), 64'd0);
            chk("md_rel_flushm", 64'(fm[0]), 64'd0);
         end
         if (i == 3) begin
            chk("md_busy_br_flushd", 64'(fd[0]), 64'd0);
            chk("md_busy_br_flushe", 64'(fe[0]), 64'd0);
            PCSrcE = 1'b0;
         end
         if (i == 0) begin
            chk("lat1_stallf", 64'(sf[1]), 64'd0);
            chk("lat1_mdbusy", 64'(mb[1]), 64'd0);
            chk("lat2_stallf", 64'(sf[2]), 64'd1);
         end
         if (i == 1) begin
            chk("lat2_release", 64'(sf[2]), 64'd0);
            chk("lat2_count", 64'(sc[2]), 64'd1);
         end
         tick();
      end
      MulDivE = 1'b0;
      #1;
      chk("md_after_busy", 64'(mb[0]), 64'd0);
      chk("md_after_stallf", 64'(sf[0]), 64'd0);
      chk("md_stallcyc7", 64'(sc[0]), 64'd7);
      chk("md_flushev0", 64'(fc[0]), 64'd0);

      pulse_reset();
      PCSrcE = 1'b1; MulDivE = 1'b1;
      #1;
      chk("br_md_flushd", 64'(fd[0]), 64'd1);
      chk("br_md_flushe", 64'(fe[0]), 64'd1);
      chk("br_md_stallf", 64'(sf[0]), 64'd0);
      tick();
      PCSrcE = 1'b0; MulDivE = 1'b0;
      #1;
      chk("br_md_no_busy", 64'(mb[0]), 64'd0);
      chk("br_md_flushev", 64'(fc[0]), 64'd1);
      chk("br_md_stallcyc", 64'(sc[0]), 64'd0);

      pulse_reset();
      MulDivE = 1'b1;
      tick();
      tick();
      chk("midrst_pre_stallf", 64'(sf[0]), 64'd1);
      chk("midrst_pre_count", 64'(sc[0]), 64'd2);
      reset = 1'b1;
      #1;
      chk("midrst_stallf", 64'(sf[0]), 64'd0);
      chk("midrst_stalle", 64'(se[0]), 64'd0);
      chk("midrst_flushm", 64'(fm[0]), 64'd0);
      chk("midrst_mdbusy", 64'(mb[0]), 64'd0);
      chk("midrst_count", 64'(sc[0]), 64'd0);
      MulDivE = 1'b0;
      reset = 1'b0;
      tick();
      chk("midrst_no_resume", 64'(sf[0]), 64'd0);

      pulse_reset();
      ResultSrcEb0 = 1'b1; RegWriteE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
      repeat (20) tick();
      chk("sat_cnt4", 64'(sc4), 64'd15);
      chk("sat_cnt32", 64'(sc[0]), 64'd20);
      ClrCnt = 1'b1;
      tick();
      chk("clr_cnt4", 64'(sc4), 64'd0);
      chk("clr_cnt32", 64'(sc[0]), 64'd0);
      ClrCnt = 1'b0;
      tick();
      chk("clr_resume", 64'(sc4), 64'd1);
      {ResultSrcEb0, RegWriteE, RdE, Rs2D} = '0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
